shift_mix_stage: RTL and testbench

SHIFT_MIX_STAGE -- requirements
Module: shift_mix_stage

---
 rtl/shift_mix_if.sv | 11 +
 rtl/shift_mix_stage.sv | 88 ++++++++
 tb/tb_shift_mix_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/shift_mix_if.sv
// shift_mix_if: data/handshake bundle between SubBytes and the ShiftRows/MixColumns stage
interface shift_mix_if;
  logic [0:127] in_vector;
  logic         ShiftEN;
  logic         LastRound;
  logic [0:127] out_vector;
  logic         MixValid;
  logic         Busy;
  modport master (output in_vector, ShiftEN, LastRound, input out_vector, MixValid, Busy);
  modport slave  (input in_vector, ShiftEN, LastRound, output out_vector, MixValid, Busy);
endinterface

// File: rtl/shift_mix_stage.sv
// shift_mix_stage: AES ShiftRows at accept, then MixColumns over COLS_PER_CYCLE columns per clock
module shift_mix_stage #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic        clk,
  input logic        rst,
  shift_mix_if.slave bus
);
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic {IDLE, MIX} state_t;
  state_t       state, nxt;
  logic [0:127] w, sr, mixed;
  logic [1:0]   cnt;
  logic         accept, last_col;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // byte (r,c) sits at index r+4c; row r rotates left by r columns
  function automatic logic [0:127] shift_rows(input logic [0:127] v);
    logic [0:127] s;
    s = v;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[8*(r+4*c) +: 8] = v[8*(r+4*((c+r)%4)) +: 8];
    return s;
  endfunction

  assign sr       = shift_rows(bus.in_vector);
  assign accept   = state == IDLE && bus.ShiftEN;
  assign last_col = int'(cnt) + COLS_PER_CYCLE == 4;

  // the counter is always a multiple of COLS_PER_CYCLE, so group membership selects the active columns
  always_comb begin
    mixed = w;
    for (int c = 0; c < 4; c++)
      if (c / COLS_PER_CYCLE == int'(cnt) / COLS_PER_CYCLE)
        mixed[32*c +: 32] = mix_col(w[32*c +: 32]);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;

  always_comb begin
    nxt      = (accept && !bus.LastRound) ? MIX : (state == MIX && last_col) ? IDLE : state;
    bus.Busy = state == MIX;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_vector <= '0;
      bus.MixValid   <= 1'b0;
      w              <= '0;
      cnt            <= '0;
    end else begin
      bus.MixValid <= 1'b0;
      if (accept) begin
        if (bus.LastRound) begin
          bus.out_vector <= sr;
          bus.MixValid   <= 1'b1;
        end else begin
          w   <= sr;
          cnt <= '0;
        end
      end else if (state == MIX) begin
        w   <= mixed;
        cnt <= last_col ? 2'd0 : cnt + 2'(COLS_PER_CYCLE);
        if (last_col) begin
          bus.out_vector <= mixed;
          bus.MixValid   <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_shift_mix_stage.sv
// tb_shift_mix_stage: three stage instances (1/2/4 columns per cycle) against a byte-array AES round model
module tb_shift_mix_stage;
  localparam int NC[3] = '{1, 2, 4};
  localparam logic [0:127] R1 = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [0:127] F1 = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [0:127] L1 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [0:127] C0 = 128'hdb000000_00130000_00005300_00000045;
  localparam logic [0:127] CF = 128'h8e4da1bc_00000000_00000000_00000000;
  localparam logic [0:127] CL = 128'hdb135345_00000000_00000000_00000000;

  logic clk = 0, rst = 1, en = 0, last = 0, chk_on = 0;
  logic [0:127] vin = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  shift_mix_if i1(), i2(), i4();
  assign i1.in_vector = vin; assign i1.ShiftEN = en; assign i1.LastRound = last;
  assign i2.in_vector = vin; assign i2.ShiftEN = en; assign i2.LastRound = last;
  assign i4.in_vector = vin; assign i4.ShiftEN = en; assign i4.LastRound = last;

  shift_mix_stage #(.COLS_PER_CYCLE(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  shift_mix_stage #(.COLS_PER_CYCLE(2)) u2 (.clk(clk), .rst(rst), .bus(i2));
  shift_mix_stage #(.COLS_PER_CYCLE(4)) u4 (.clk(clk), .rst(rst), .bus(i4));

  logic [0:127] outv [3];
  logic val [3], bsy [3];
  assign outv[0] = i1.out_vector; assign val[0] = i1.MixValid; assign bsy[0] = i1.Busy;
  assign outv[1] = i2.out_vector; assign val[1] = i2.MixValid; assign bsy[1] = i2.Busy;
  assign outv[2] = i4.out_vector; assign val[2] = i4.MixValid; assign bsy[2] = i4.Busy;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [0:127] ref_round(input logic [0:127] v, input logic lr);
    logic [7:0] s [4][4];
    logic [7:0] t [4];
    logic [0:127] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = v[8*(r+4*((c+r)%4)) +: 8];
    if (!lr)
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++)
          t[r] = gmul(8'd2, s[r][c]) ^ gmul(8'd3, s[(r+1)%4][c]) ^ s[(r+2)%4][c] ^ s[(r+3)%4][c];
        for (int r = 0; r < 4; r++) s[r][c] = t[r];
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r+4*c) +: 8] = s[r][c];
    return o;
  endfunction

  // reference: remaining-edge countdown per instance, result computed up front
  int left [3];
  logic [0:127] pend [3], mout [3];
  logic mval [3];
  always @(posedge clk or posedge rst)
    for (int k = 0; k < 3; k++)
      if (rst) begin
        left[k] <= 0; pend[k] <= '0; mout[k] <= '0; mval[k] <= 0;
      end else begin
        mval[k] <= 0;
        if (left[k] > 0) begin
          left[k] <= left[k] - 1;
          if (left[k] == 1) begin mval[k] <= 1; mout[k] <= pend[k]; end
        end else if (en) begin
          if (last) begin mval[k] <= 1; mout[k] <= ref_round(vin, 1'b1); end
          else begin pend[k] <= ref_round(vin, 1'b0); left[k] <= 4 / NC[k]; end
        end
      end

  always @(negedge clk)
    if (chk_on)
      for (int k = 0; k < 3; k++) begin
        check($sformatf("model_valid_n%0d", NC[k]), val[k], mval[k]);
        check($sformatf("model_busy_n%0d", NC[k]), bsy[k], left[k] > 0);
        check($sformatf("model_out_n%0d", NC[k]), outv[k], mout[k]);
      end

  task automatic run_vec(input logic [0:127] v, input logic lr, input logic [0:127] exp,
                         input logic ovl, input string nm);
    int lat [3] = '{-1, -1, -1};
    int pulses [3] = '{0, 0, 0};
    logic [0:127] res [3];
    @(negedge clk); #1 vin = v; last = lr; en = 1;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (val[k]) begin
          pulses[k]++;
          if (lat[k] < 0) begin lat[k] = j; res[k] = outv[k]; end
        end
      #1;
      if (j == 0 && ovl) begin vin = C0; last = 1; end
      else en = 0;
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_lat_n%0d", nm, NC[k]), lat[k], lr ? 0 : 4 / NC[k]);
      check($sformatf("%s_out_n%0d", nm, NC[k]), res[k], exp);
      check($sformatf("%s_pulses_n%0d", nm, NC[k]), pulses[k], 1);
    end
  endtask

  typedef struct { logic [0:127] vin; logic lr; logic [0:127] exp; } vec_t;

  initial begin
    vec_t tbl [6];
    int d;
    logic found;
    tbl = '{'{R1, 1'b0, F1}, '{R1, 1'b1, L1}, '{C0, 1'b0, CF},
            '{C0, 1'b1, CL}, '{'0, 1'b0, '0}, '{R1, 1'b0, F1}};
    @(negedge clk); #1 en = 1; vin = R1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_out", outv[k], '0);
      check("reset_valid", val[k], 0);
      check("reset_busy", bsy[k], 0);
    end
    #1 rst = 0; en = 0; chk_on = 1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) check("en_during_reset_ignored", {bsy[k], val[k]}, 0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i].vin, tbl[i].lr, tbl[i].exp, 1'b0, $sformatf("vec%0d", i));
    run_vec(R1, 1'b0, F1, 1'b1, "overlap");

    // back-to-back on the single-column instance
    @(negedge clk); #1 en = 1; vin = R1; last = 0;
    @(negedge clk); #1 en = 0;
    found = 0;
    for (int j = 1; j < 10 && !found; j++) begin
      @(negedge clk);
      if (val[0]) begin found = 1; check("b2b_first_out", outv[0], F1); #1 en = 1; vin = C0; end
    end
    check("b2b_first_seen", found, 1);
    @(negedge clk); #1 en = 0;
    d = -1;
    for (int j = 1; j < 9; j++) begin
      @(negedge clk);
      if (val[0] && d < 0) begin d = j; check("b2b_second_out", outv[0], CF); end
    end
    check("b2b_second_lat", d, 4);

    // reset mid-operation
    @(negedge clk); #1 en = 1; vin = R1; last = 0;
    for (int j = 0; j < 3; j++) begin @(negedge clk); if (j == 0) #1 en = 0; end
    #1 rst = 1; #1;
    for (int k = 0; k < 3; k++) begin
      check("midrst_out", outv[k], '0);
      check("midrst_valid", val[k], 0);
      check("midrst_busy", bsy[k], 0);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1 en = (j == 1);
      for (int k = 0; k < 3; k++) check("midrst_hold_valid", val[k], 0);
    end
    #1 rst = 0; en = 0;
    run_vec(R1, 1'b1, L1, 1'b0, "after_rst");

    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      en = $urandom_range(0, 2) == 0;
      last = $urandom_range(0, 3) == 0;
      vin = {$urandom(), $urandom(), $urandom(), $urandom()};
      rst = $urandom_range(0, 99) == 0;
    end
    @(negedge clk); #1 rst = 0; en = 0;
    repeat (8) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
